// File: rtl/mt_prng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mt_prng_pkg
//  Purpose  : Shared definitions for the mt_prng_stream generator.
//             - FSM state type (seeding / running)
//             - 32-bit seeding multiplier and tempering mask; each user
//               slices these down to its own WIDTH
//             - legal WIDTH / DEPTH limits, checked at elaboration by the top
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mt_prng_pkg;

  typedef enum logic [0:0] {
    ST_SEED = 1'b0,
    ST_RUN  = 1'b1
  } prng_state_e;

  localparam logic [31:0] C_SEED_MULT   = 32'h6C07_8965;
  localparam logic [31:0] C_TEMPER_MASK = 32'h9D2C_5680;

  localparam int C_WIDTH_MIN = 8;
  localparam int C_WIDTH_MAX = 32;
  localparam int C_DEPTH_MIN = 4;
  localparam int C_DEPTH_MAX = 16;

endpackage : mt_prng_pkg
`default_nettype wire

// File: rtl/mt_prng_temper.sv
`default_nettype none
// ============================================================================
//  Module   : mt_prng_temper
//  Purpose  : Purely combinational output tempering of one state word:
//               t = n ^ (n >> WIDTH/2)
//               t = t ^ ((t << WIDTH/4) & TMASK)
//             TMASK is the low WIDTH bits of the 32-bit tempering mask.
//  Params   : WIDTH - word width (8..32)
//  Ports    : i_n [WIDTH] - untempered word
//             o_t [WIDTH] - tempered word
//  Revision : 1.0 - initial release
// ============================================================================
module mt_prng_temper
  import mt_prng_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_t
);

  localparam logic [WIDTH-1:0] C_TMASK = C_TEMPER_MASK[WIDTH-1:0];

  logic [WIDTH-1:0] w_t1;

  assign w_t1 = i_n ^ (i_n >> (WIDTH / 2));
  assign o_t  = w_t1 ^ ((w_t1 << (WIDTH / 4)) & C_TMASK);

endmodule : mt_prng_temper
`default_nettype wire

// File: rtl/mt_prng_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mt_prng_stream
//  Purpose  : Small twisted-state pseudo-random word generator with a
//             valid/ready output stream.
//             SEED : writes one state word per cycle (DEPTH cycles total)
//             RUN  : produces one word per cycle whenever the output
//                    register is empty or being consumed.
//  Params   : WIDTH        - state/output word width (8..32)
//             DEPTH        - number of state words (4..16)
//             OUTPUT_TYPE  - 0: integer word, 1: IEEE-754 single in [1,2)
//                            (requires WIDTH=32)
//             DEFAULT_SEED - seed used after reset
//  Macro    : MT_PRNG_TEMPER_EN - when defined, output words are tempered
//             by mt_prng_temper; the state always keeps the raw word.
//  Ports    : clk        in   clock, rising edge
//             reset      in   asynchronous active-high reset
//             load_seed  in   reseed request (highest priority)
//             seed_data  in   [WIDTH] seed, sampled with load_seed
//             prng_ready in   consumer accepts prng_data
//             prng_data  out  [WIDTH] registered random word
//             prng_valid out  prng_data holds an unconsumed word
//             prng_done  out  seeding complete (FSM in RUN)
//  Revision : 1.0 - initial release
// ============================================================================
module mt_prng_stream
  import mt_prng_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          DEPTH        = 4,
  parameter int          OUTPUT_TYPE  = 0,
  parameter int unsigned DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             prng_ready,
  output logic [WIDTH-1:0] prng_data,
  output logic             prng_valid,
  output logic             prng_done
);

  localparam int               PTR_W        = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST       = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_ONE        = PTR_W'(1);
  localparam logic [WIDTH-1:0] C_MULT_W     = C_SEED_MULT[WIDTH-1:0];
  localparam logic [31:0]      C_SEED32     = 32'(DEFAULT_SEED);
  localparam logic [WIDTH-1:0] C_RESET_SEED = C_SEED32[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // --------------------------------------------------------------------------
  generate
    if (WIDTH < C_WIDTH_MIN || WIDTH > C_WIDTH_MAX) begin : g_bad_width
      $error("mt_prng_stream: WIDTH must be in 8..32");
    end
    if (DEPTH < C_DEPTH_MIN || DEPTH > C_DEPTH_MAX) begin : g_bad_depth
      $error("mt_prng_stream: DEPTH must be in 4..16");
    end
    if (OUTPUT_TYPE != 0 && OUTPUT_TYPE != 1) begin : g_bad_type
      $error("mt_prng_stream: OUTPUT_TYPE must be 0 or 1");
    end
    if (OUTPUT_TYPE == 1 && WIDTH != 32) begin : g_bad_float
      $error("mt_prng_stream: OUTPUT_TYPE=1 requires WIDTH=32");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  prng_state_e      state_q, state_d;
  logic [PTR_W-1:0] k_q, k_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];

  // --------------------------------------------------------------------------
  // Seeding recurrence: s[k] = M*(s[k-1] ^ (s[k-1] >> (WIDTH-2))) + k
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] w_k_prev;
  logic [WIDTH-1:0] w_prev;
  logic [WIDTH-1:0] w_seed_word;

  // Clamp at 0 so the (unused) k=0 read never indexes outside the array.
  assign w_k_prev    = (k_q == '0) ? '0 : (k_q - C_ONE);
  assign w_prev      = s_q[w_k_prev];
  assign w_seed_word = (k_q == '0) ? seed_q
                     : (C_MULT_W * (w_prev ^ (w_prev >> (WIDTH - 2)))) + WIDTH'(k_q);

  // --------------------------------------------------------------------------
  // Step: y = s[ptr] ^ (s[ptr] >> 1); n = y ^ (y << 1) ^ (s[ptr+1] >> 3)
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_nbr;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_shaped;
  logic [WIDTH-1:0] w_out;

  assign w_ptr_next = (ptr_q == C_LAST) ? '0 : (ptr_q + C_ONE);
  assign w_cur      = s_q[ptr_q];
  assign w_nbr      = s_q[w_ptr_next];
  assign w_y        = w_cur ^ (w_cur >> 1);
  assign w_step     = w_y ^ (w_y << 1) ^ (w_nbr >> 3);

`ifdef MT_PRNG_TEMPER_EN
  mt_prng_temper #(
    .WIDTH (WIDTH)
  ) u_temper (
    .i_n (w_step),
    .o_t (w_shaped)
  );
`else
  assign w_shaped = w_step;
`endif

  generate
    if (OUTPUT_TYPE == 1) begin : g_float_out
      // Sign 0, biased exponent 127, random mantissa -> value in [1.0, 2.0)
      assign w_out = {1'b0, 8'd127, w_shaped[22:0]};
    end else begin : g_int_out
      assign w_out = w_shaped;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    seed_d  = seed_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    for (int i = 0; i < DEPTH; i++) begin
      s_d[i] = s_q[i];
    end

    if (load_seed) begin
      // Reseed wins over everything, including a pending handshake: the
      // held word is dropped rather than transferred.
      seed_d  = seed_data;
      state_d = ST_SEED;
      k_d     = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (state_q == ST_SEED) begin
      s_d[k_q] = w_seed_word;
      if (k_q == C_LAST) begin
        state_d = ST_RUN;
        k_d     = '0;
        ptr_d   = '0;
        done_d  = 1'b1;
      end else begin
        k_d = k_q + C_ONE;
      end
    end else if (!valid_q || prng_ready) begin
      // Output register empty or being consumed this edge: advance.
      s_d[ptr_q] = w_step;
      ptr_d      = w_ptr_next;
      data_d     = w_out;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEED;
      k_q     <= '0;
      ptr_q   <= '0;
      seed_q  <= C_RESET_SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign prng_data  = data_q;
  assign prng_valid = valid_q;
  assign prng_done  = done_q;

endmodule : mt_prng_stream
`default_nettype wire

// File: tb/tb_mt_prng_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mt_prng_stream
//  Purpose  : Self-checking bench. Instance A: WIDTH=8, DEPTH=4, integer
//             output. Instance B: WIDTH=32, DEPTH=16, float output.
//             A sequence-level model (seed table + word generator + stream
//             occupancy) predicts valid/done/data for both every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mt_prng_stream;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;

  logic        ld_a  = 1'b0;
  logic [7:0]  sd_a  = 8'h00;
  logic        rdy_a = 1'b1;
  logic [7:0]  data_a;
  logic        valid_a, done_a;

  logic        ld_b  = 1'b0;
  logic [31:0] sd_b  = 32'h0;
  logic        rdy_b = 1'b1;
  logic [31:0] data_b;
  logic        valid_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mt_prng_stream #(
    .WIDTH(8), .DEPTH(4), .OUTPUT_TYPE(0), .DEFAULT_SEED(1)
  ) dut_a (
    .clk(clk), .reset(reset), .load_seed(ld_a), .seed_data(sd_a),
    .prng_ready(rdy_a), .prng_data(data_a), .prng_valid(valid_a),
    .prng_done(done_a)
  );

  mt_prng_stream #(
    .WIDTH(32), .DEPTH(16), .OUTPUT_TYPE(1), .DEFAULT_SEED(1)
  ) dut_b (
    .clk(clk), .reset(reset), .load_seed(ld_b), .seed_data(sd_b),
    .prng_ready(rdy_b), .prng_data(data_b), .prng_valid(valid_b),
    .prng_done(done_b)
  );

  // --------------------------------------------------------------------------
  // Model
  // --------------------------------------------------------------------------
  localparam int unsigned MULT  = 32'h6C07_8965;
  localparam int unsigned TMASK = 32'h9D2C_5680;

  int unsigned gs [3][16];   // [0]=A, [1]=B, [2]=scratch
  int          gptr [3];
  int          seed_left [2];
  bit          ex_valid [2];
  bit          ex_done [2];
  int unsigned ex_data [2];

  // First words after seeding WIDTH=8/DEPTH=4 with 0x00, worked by hand.
  int unsigned ref_a [5] = '{32'h00, 32'h0F, 32'hF4, 32'hA3, 32'h01};

  logic [7:0] got_q [$];
  int         b_words = 0;

  function automatic int unsigned msk(int w, int unsigned v);
    if (w >= 32) return v;
    return v & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic void gen_seed(int i, int w, int d, int unsigned seed);
    int unsigned x;
    gs[i][0] = msk(w, seed);
    for (int k = 1; k < d; k++) begin
      x        = gs[i][k-1];
      gs[i][k] = msk(w, MULT * (x ^ (x >> (w - 2))) + k);
    end
    gptr[i] = 0;
  endfunction

  function automatic int unsigned gen_step(int i, int w, int d);
    int unsigned s, y, n, t;
    int p;
    p  = gptr[i];
    s  = gs[i][p];
    y  = s ^ (s >> 1);
    n  = msk(w, y ^ (y << 1) ^ (gs[i][(p + 1) % d] >> 3));
    gs[i][p] = n;
    gptr[i]  = (p + 1) % d;
    t = n;
`ifdef MT_PRNG_TEMPER_EN
    t = n ^ (n >> (w / 2));
    t = msk(w, t ^ ((t << (w / 4)) & TMASK));
`endif
    return t;
  endfunction

  function automatic void model_reset(int i, int w, int d);
    gen_seed(i, w, d, 1);
    seed_left[i] = d;
    ex_valid[i]  = 1'b0;
    ex_done[i]   = 1'b0;
    ex_data[i]   = 0;
  endfunction

  function automatic void model_tick(int i, int w, int d, bit is_float,
                                     bit ld, int unsigned sd, bit rdy);
    int unsigned t;
    if (ld) begin
      gen_seed(i, w, d, sd);
      seed_left[i] = d;
      ex_valid[i]  = 1'b0;
      ex_done[i]   = 1'b0;
    end else if (seed_left[i] > 0) begin
      seed_left[i]--;
      if (seed_left[i] == 0) ex_done[i] = 1'b1;
    end else if (!ex_valid[i] || rdy) begin
      t = gen_step(i, w, d);
      ex_data[i]  = is_float ? (32'h3F80_0000 | (t & 32'h007F_FFFF)) : t;
      ex_valid[i] = 1'b1;
    end
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      model_reset(0, 8, 4);
      model_reset(1, 32, 16);
    end else begin
      model_tick(0, 8, 4, 1'b0, ld_a, {24'h0, sd_a}, rdy_a);
      model_tick(1, 32, 16, 1'b1, ld_b, sd_b, rdy_b);
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("a_valid", {31'h0, valid_a}, {31'h0, ex_valid[0]});
    chk("a_done",  {31'h0, done_a},  {31'h0, ex_done[0]});
    if (ex_valid[0] || reset) chk("a_data", {24'h0, data_a}, ex_data[0]);
    chk("b_valid", {31'h0, valid_b}, {31'h0, ex_valid[1]});
    chk("b_done",  {31'h0, done_b},  {31'h0, ex_done[1]});
    if (ex_valid[1] || reset) chk("b_data", data_b, ex_data[1]);
    if (valid_b) chk("b_exponent_field", {23'h0, data_b[31:23]}, 32'h07F);
    if (valid_a && rdy_a && !ld_a && !reset) got_q.push_back(data_a);
    if (valid_b && rdy_b && !ld_b && !reset) b_words++;
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reseed A with 0x00 while ready=1, count the invalid cycles, then
  // optionally apply backpressure, and compare consumed words to ref_a.
  task automatic reseed_zero(input bit with_bp);
    int n;
    logic [7:0] held;
    got_q.delete();
    ld_a = 1'b1; sd_a = 8'h00; rdy_a = 1'b1;
    step(1);
    ld_a = 1'b0;
    n = 0;
    while (!valid_a && n < 20) begin
      n++;
      step(1);
    end
    chk("reseed_valid_low_cycles", n, 5);
    chk("reseed_first_word", {24'h0, data_a}, ref_a[0]);
    if (with_bp) begin
      step(1);
      rdy_a = 1'b0;
      held  = data_a;
      chk("bp_held_word", {24'h0, held}, ref_a[1]);
      for (int c = 0; c < 5; c++) begin
        step(1);
        chk("bp_data_stable", {24'h0, data_a}, {24'h0, held});
        chk("bp_valid_high", {31'h0, valid_a}, 32'h1);
      end
      rdy_a = 1'b1;
    end
    step(6);
    chk("ref_seq_length_ok", {31'h0, got_q.size() >= 5}, 32'h1);
    if (got_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("ref_seq_word", {24'h0, got_q[k]}, ref_a[k]);
    end
  endtask

  initial begin
    int n;

    // Pin the model to hand-computed values.
    gen_seed(2, 8, 4, 0);
    chk("pin_seed_s0", gs[2][0], 32'h00);
    chk("pin_seed_s1", gs[2][1], 32'h01);
    chk("pin_seed_s2", gs[2][2], 32'h67);
    chk("pin_seed_s3", gs[2][3], 32'h41);
`ifndef MT_PRNG_TEMPER_EN
    for (int k = 0; k < 5; k++) chk("pin_model_word", gen_step(2, 8, 4), ref_a[k]);
`endif

    // Reset, then default-seed start-up latency.
    step(3);
    reset = 1'b0;
    n = 0;
    while (!valid_a && n < 20) begin
      step(1);
      n++;
    end
    chk("first_valid_latency", n, 5);
    step(8);

    // Reseed in RUN with ready=1, backpressure, continuity.
`ifndef MT_PRNG_TEMPER_EN
    reseed_zero(1'b1);
    step(4);
    // Second identical restart.
    reseed_zero(1'b0);
    // Reseed during SEED restarts with the newer seed.
    ld_a = 1'b1; sd_a = 8'h55;
    step(1);
    ld_a = 1'b0;
    step(2);
    reseed_zero(1'b0);
`endif

    // Asynchronous reset mid-RUN.
    step(3);
    reset = 1'b1;
    #1;
    chk("async_rst_a_data",  {24'h0, data_a}, 32'h0);
    chk("async_rst_a_valid", {31'h0, valid_a}, 32'h0);
    chk("async_rst_a_done",  {31'h0, done_a}, 32'h0);
    chk("async_rst_b_data",  data_b, 32'h0);
    chk("async_rst_b_valid", {31'h0, valid_b}, 32'h0);
    step(2);
    reset   = 1'b0;
    b_words = 0;

    // Mixed readiness on both instances.
    for (int c = 0; c < 150; c++) begin
      rdy_a = 1'($urandom_range(0, 1));
      rdy_b = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Run B to at least 1000 words (16-deep pointer wraps many times).
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    n = 0;
    while (b_words < 1000 && n < 3000) begin
      step(1);
      n++;
    end
    chk("b_words_reached_1000", {31'h0, b_words >= 1000}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mt_prng_stream
`default_nettype wire
